// File: rtl/change_dispenser_if.sv
// Bundle of request, inventory-load, solenoid and status signals between the
// vending controller (master) and the change dispenser (slave).
interface change_dispenser_if #(
  parameter int AMT_W = 5,
  parameter int CNT_W = 8
);
  // Change request handshake
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;

  // Inventory load
  logic             load_en;
  logic [CNT_W-1:0] load_q;
  logic [CNT_W-1:0] load_d;
  logic [CNT_W-1:0] load_n;

  // Hopper solenoids
  logic             eject_q;
  logic             eject_d;
  logic             eject_n;

  // Status
  logic             busy;
  logic             done;
  logic             short;
  logic [AMT_W-1:0] shortfall;
  logic [CNT_W-1:0] inv_q;
  logic [CNT_W-1:0] inv_d;
  logic [CNT_W-1:0] inv_n;

  // Vending controller side
  modport master (
    output req_valid, req_amount, load_en, load_q, load_d, load_n,
    input  req_ready, eject_q, eject_d, eject_n, busy, done, short,
           shortfall, inv_q, inv_d, inv_n
  );

  // Dispenser side
  modport slave (
    input  req_valid, req_amount, load_en, load_q, load_d, load_n,
    output req_ready, eject_q, eject_d, eject_n, busy, done, short,
           shortfall, inv_q, inv_d, inv_n
  );
endinterface

// File: rtl/change_dispenser.sv
// Coin payout controller: pays a nickel-unit amount one coin at a time,
// largest coin first (quarter, dime, nickel), holding each solenoid for a
// fixed pulse followed by a fixed all-off gap. Reports any unpaid remainder.
module change_dispenser #(
  parameter int AMT_W        = 5,
  parameter int CNT_W        = 8,
  parameter int PULSE_CYCLES = 250000000,
  parameter int GAP_CYCLES   = 50000000,
  parameter int TMR_W        = 28
) (
  input logic               clk,
  input logic               rst_n,
  change_dispenser_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_GAP,
    ST_DONE
  } state_t;

  // Coin values in nickel units and last timer counts of pulse/gap
  localparam logic [AMT_W-1:0] QUARTER_VAL = AMT_W'(5);
  localparam logic [AMT_W-1:0] DIME_VAL    = AMT_W'(2);
  localparam logic [AMT_W-1:0] NICKEL_VAL  = AMT_W'(1);
  localparam logic [TMR_W-1:0] PULSE_LAST  = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST    = TMR_W'(GAP_CYCLES - 1);

  // State and datapath registers
  state_t           r_state;
  logic [AMT_W-1:0] r_rem;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_inv_q;
  logic [CNT_W-1:0] r_inv_d;
  logic [CNT_W-1:0] r_inv_n;
  logic             r_eject_q;
  logic             r_eject_d;
  logic             r_eject_n;
  logic [AMT_W-1:0] r_shortfall;
  logic             r_done;
  logic             r_short;

  // Next-state values
  state_t           w_state_next;
  logic [AMT_W-1:0] w_rem_next;
  logic [TMR_W-1:0] w_timer_next;
  logic [CNT_W-1:0] w_inv_q_next;
  logic [CNT_W-1:0] w_inv_d_next;
  logic [CNT_W-1:0] w_inv_n_next;
  logic             w_eject_q_next;
  logic             w_eject_d_next;
  logic             w_eject_n_next;
  logic [AMT_W-1:0] w_shortfall_next;
  logic             w_done_next;
  logic             w_short_next;

  // Coin availability: enough owed and at least one coin in the hopper
  logic w_req_ready;
  logic w_accept;
  logic w_can_q;
  logic w_can_d;
  logic w_can_n;

  // Load has priority over a request arriving in the same idle cycle
  assign w_req_ready = (r_state == ST_IDLE) & ~bus.load_en;
  assign w_accept    = bus.req_valid & w_req_ready;

  assign w_can_q = (r_rem >= QUARTER_VAL) && (r_inv_q != '0);
  assign w_can_d = (r_rem >= DIME_VAL)    && (r_inv_d != '0);
  assign w_can_n = (r_rem >= NICKEL_VAL)  && (r_inv_n != '0);

  // Next-state and datapath decode; every target defaults to hold
  always_comb begin
    w_state_next     = r_state;
    w_rem_next       = r_rem;
    w_timer_next     = r_timer;
    w_inv_q_next     = r_inv_q;
    w_inv_d_next     = r_inv_d;
    w_inv_n_next     = r_inv_n;
    w_eject_q_next   = r_eject_q;
    w_eject_d_next   = r_eject_d;
    w_eject_n_next   = r_eject_n;
    w_shortfall_next = r_shortfall;
    w_done_next      = 1'b0;
    w_short_next     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.load_en) begin
          // Replace, not add: the operator loads an absolute count
          w_inv_q_next = bus.load_q;
          w_inv_d_next = bus.load_d;
          w_inv_n_next = bus.load_n;
        end else if (w_accept) begin
          w_rem_next       = bus.req_amount;
          w_shortfall_next = '0;
          w_timer_next     = '0;
          w_state_next     = ST_SELECT;
        end
      end

      ST_SELECT: begin
        w_timer_next = '0;
        if (r_rem == '0) begin
          w_done_next  = 1'b1;
          w_state_next = ST_DONE;
        end else if (w_can_q) begin
          w_rem_next     = r_rem - QUARTER_VAL;
          w_inv_q_next   = r_inv_q - 1'b1;
          w_eject_q_next = 1'b1;
          w_state_next   = ST_EJECT;
        end else if (w_can_d) begin
          w_rem_next     = r_rem - DIME_VAL;
          w_inv_d_next   = r_inv_d - 1'b1;
          w_eject_d_next = 1'b1;
          w_state_next   = ST_EJECT;
        end else if (w_can_n) begin
          w_rem_next     = r_rem - NICKEL_VAL;
          w_inv_n_next   = r_inv_n - 1'b1;
          w_eject_n_next = 1'b1;
          w_state_next   = ST_EJECT;
        end else begin
          // Greedy cannot continue: whatever is left goes unpaid
          w_shortfall_next = r_rem;
          w_done_next      = 1'b1;
          w_short_next     = 1'b1;
          w_state_next     = ST_DONE;
        end
      end

      ST_EJECT: begin
        if (r_timer == PULSE_LAST) begin
          w_timer_next   = '0;
          w_eject_q_next = 1'b0;
          w_eject_d_next = 1'b0;
          w_eject_n_next = 1'b0;
          w_state_next   = ST_GAP;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end

      ST_GAP: begin
        if (r_timer == GAP_LAST) begin
          w_timer_next = '0;
          w_state_next = ST_SELECT;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end

      ST_DONE: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next   = ST_IDLE;
        w_eject_q_next = 1'b0;
        w_eject_d_next = 1'b0;
        w_eject_n_next = 1'b0;
      end
    endcase
  end

  // State register; reset drops any solenoid immediately and clears accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_timer     <= '0;
      r_inv_q     <= '0;
      r_inv_d     <= '0;
      r_inv_n     <= '0;
      r_eject_q   <= 1'b0;
      r_eject_d   <= 1'b0;
      r_eject_n   <= 1'b0;
      r_shortfall <= '0;
      r_done      <= 1'b0;
      r_short     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rem       <= w_rem_next;
      r_timer     <= w_timer_next;
      r_inv_q     <= w_inv_q_next;
      r_inv_d     <= w_inv_d_next;
      r_inv_n     <= w_inv_n_next;
      r_eject_q   <= w_eject_q_next;
      r_eject_d   <= w_eject_d_next;
      r_eject_n   <= w_eject_n_next;
      r_shortfall <= w_shortfall_next;
      r_done      <= w_done_next;
      r_short     <= w_short_next;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.eject_q   = r_eject_q;
  assign bus.eject_d   = r_eject_d;
  assign bus.eject_n   = r_eject_n;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign bus.short     = r_short;
  assign bus.shortfall = r_shortfall;
  assign bus.inv_q     = r_inv_q;
  assign bus.inv_d     = r_inv_d;
  assign bus.inv_n     = r_inv_n;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with PULSE_CYCLES=4, GAP_CYCLES=2.
module tb_change_dispenser;

  localparam int AMT_W = 5;
  localparam int CNT_W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  change_dispenser_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bus ();

  change_dispenser #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .PULSE_CYCLES(4), .GAP_CYCLES(2), .TMR_W(4)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int q, input int d, input int n);
    bus.load_en = 1'b1;
    bus.load_q  = CNT_W'(q);
    bus.load_d  = CNT_W'(d);
    bus.load_n  = CNT_W'(n);
    step();
    bus.load_en = 1'b0;
    $display("load q=%0d d=%0d n=%0d", q, d, n);
  endtask

  // Issues one request and watches it cycle by cycle (cycle 1 = first after accept).
  task automatic run_req(input int amount, input int budget,
                         output int done_cyc, output int fq, output int fd, output int fn,
                         output int cq, output int cd, output int cn,
                         output int multi, output logic shrt, output int sf);
    done_cyc = -1; fq = -1; fd = -1; fn = -1;
    cq = 0; cd = 0; cn = 0; multi = 0; shrt = 1'bx; sf = -1;
    bus.req_valid  = 1'b1;
    bus.req_amount = AMT_W'(amount);
    step();
    bus.req_valid  = 1'b0;
    bus.req_amount = '0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (bus.eject_q) begin cq++; if (fq < 0) fq = cyc; end
      if (bus.eject_d) begin cd++; if (fd < 0) fd = cyc; end
      if (bus.eject_n) begin cn++; if (fn < 0) fn = cyc; end
      if ((32'(bus.eject_q) + 32'(bus.eject_d) + 32'(bus.eject_n)) > 1) multi++;
      if (bus.done) begin
        done_cyc = cyc;
        shrt     = bus.short;
        sf       = int'(bus.shortfall);
        break;
      end
      step();
    end
    $display("req amount=%0d done_cycle=%0d q=%0d d=%0d n=%0d short=%0b shortfall=%0d",
             amount, done_cyc, cq, cd, cn, shrt, sf);
  endtask

  int   dc, fq, fd, fn, cq, cd, cn, multi, sf;
  logic shrt;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_amount = '0;
    bus.load_en = 1'b0; bus.load_q = '0; bus.load_d = '0; bus.load_n = '0;
    #12;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_eject", {bus.eject_q, bus.eject_d, bus.eject_n}, 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_short", 32'(bus.short), 0);
    check("rst_shortfall", 32'(bus.shortfall), 0);
    check("rst_inv", {bus.inv_q, bus.inv_d, bus.inv_n}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_ready", 32'(bus.req_ready), 1);

    // Scenario 1: amount 0
    bus.load_en = 1'b1;
    #1;
    check("ready_low_on_load", 32'(bus.req_ready), 0);
    bus.load_en = 1'b0;
    load(2, 2, 2);
    check("load_inv", {bus.inv_q, bus.inv_d, bus.inv_n}, {8'd2, 8'd2, 8'd2});
    run_req(0, 20, dc, fq, fd, fn, cq, cd, cn, multi, shrt, sf);
    check("z_done_cycle", dc, 2);
    check("z_ejects", cq + cd + cn, 0);
    check("z_short", 32'(shrt), 0);
    step();
    check("z_idle_after", 32'(bus.busy), 0);
    check("z_done_pulse", 32'(bus.done), 0);
    check("z_inv", {bus.inv_q, bus.inv_d, bus.inv_n}, {8'd2, 8'd2, 8'd2});

    // Scenario 2: 40c from 2/2/2 -> quarter, dime, nickel
    run_req(8, 60, dc, fq, fd, fn, cq, cd, cn, multi, shrt, sf);
    check("e_done_cycle", dc, 23);
    check("e_first_q", fq, 2);
    check("e_first_d", fd, 9);
    check("e_first_n", fn, 16);
    check("e_len_q", cq, 4);
    check("e_len_d", cd, 4);
    check("e_len_n", cn, 4);
    check("e_onehot", multi, 0);
    check("e_short", 32'(shrt), 0);
    check("e_shortfall", sf, 0);
    step();
    check("e_inv", {bus.inv_q, bus.inv_d, bus.inv_n}, {8'd1, 8'd1, 8'd1});

    // Scenario 3: 6 from 1/3/0 -> quarter, then greedy stalls at 1
    load(1, 3, 0);
    run_req(6, 40, dc, fq, fd, fn, cq, cd, cn, multi, shrt, sf);
    check("g_done_cycle", dc, 9);
    check("g_len_q", cq, 4);
    check("g_len_dn", cd + cn, 0);
    check("g_short", 32'(shrt), 1);
    check("g_shortfall", sf, 1);
    step();
    check("g_short_pulse", 32'(bus.short), 0);
    check("g_shortfall_hold", 32'(bus.shortfall), 1);
    check("g_inv", {bus.inv_q, bus.inv_d, bus.inv_n}, {8'd0, 8'd3, 8'd0});

    // Scenario 4: 31 with empty hoppers
    load(0, 0, 0);
    run_req(31, 20, dc, fq, fd, fn, cq, cd, cn, multi, shrt, sf);
    check("x_done_cycle", dc, 2);
    check("x_ejects", cq + cd + cn, 0);
    check("x_short", 32'(shrt), 1);
    check("x_shortfall", sf, 31);
    step();

    // Scenario 5: load and request together; load wins
    bus.load_en = 1'b1; bus.load_q = 8'd3; bus.load_d = 8'd0; bus.load_n = 8'd0;
    bus.req_valid = 1'b1; bus.req_amount = 5'd5;
    #1;
    check("lr_ready_low", 32'(bus.req_ready), 0);
    step();
    bus.load_en = 1'b0;
    #1;
    check("lr_not_accepted", 32'(bus.busy), 0);
    check("lr_shortfall_kept", 32'(bus.shortfall), 31);
    check("lr_inv_q", 32'(bus.inv_q), 3);
    check("lr_ready_high", 32'(bus.req_ready), 1);
    step();
    bus.req_valid = 1'b0;
    $display("req amount=5 accepted after load");
    check("lr_accepted", 32'(bus.busy), 1);
    check("lr_shortfall_clr", 32'(bus.shortfall), 0);
    step();
    check("lr_eject_q", 32'(bus.eject_q), 1);
    check("lr_inv_q_dec", 32'(bus.inv_q), 2);

    // Scenario 6: reset during the pulse
    step();
    #3;
    rst_n = 1'b0;
    #1;
    $display("reset asserted mid-eject");
    check("ar_eject", {bus.eject_q, bus.eject_d, bus.eject_n}, 0);
    check("ar_busy", 32'(bus.busy), 0);
    check("ar_inv", {bus.inv_q, bus.inv_d, bus.inv_n}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ar_ready", 32'(bus.req_ready), 1);
    check("ar_eject_after", {bus.eject_q, bus.eject_d, bus.eject_n}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Coin payout controller for the soda vending machine.
- Takes a change amount in nickel units and drives the quarter, dime and nickel hopper eject solenoids one coin at a time, using a greedy largest-coin-first order.
- Tracks the per-coin inventory and reports a shortfall when it cannot pay the full amount.
- Sits between the vending FSM's change request and the physical coin hoppers.

Parameters:
AMT_W, 5, width of amount and remainder in nickel units (max 31 = $1.55)
CNT_W, 8, width of each coin inventory counter
PULSE_CYCLES, 250000000, clk cycles each eject line is held high per coin
GAP_CYCLES, 50000000, clk cycles with all eject lines low between coins
TMR_W, 28, width of the pulse/gap timer (must hold max(PULSE_CYCLES, GAP_CYCLES))

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  change request present
req_amount  input  AMT_W  change owed, nickel units
req_ready  output  1  high when a request can be accepted
load_en  input  1  load inventory counters (honoured in IDLE only)
load_q  input  CNT_W  quarter count to load
load_d  input  CNT_W  dime count to load
load_n  input  CNT_W  nickel count to load
eject_q  output  1  quarter solenoid
eject_d  output  1  dime solenoid
eject_n  output  1  nickel solenoid
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a request completes
short  output  1  one-cycle pulse coincident with done when payout was incomplete
shortfall  output  AMT_W  nickel units not paid; holds until the next accepted request
inv_q, inv_d, inv_n  output  CNT_W each  current inventory

Behaviour:
- Reset (asynchronous, active-low) forces the following immediately:
  - state=IDLE
  - all eject outputs 0
  - done=0, short=0, busy=0
  - shortfall=0, inventory=0, remainder=0, timer=0
- Reset mid-eject drops the solenoid at once. No coin accounting is retained.
- req_ready = (state==IDLE) & ~load_en. Load wins over a simultaneous request; that request is not accepted.
- Load: in IDLE with load_en=1, the inventories take load_q/d/n on the next edge (replace, not add). load_en is ignored in other states.
- Accept: on an edge where req_valid & req_ready:
  - rem <= req_amount, shortfall <= 0, state <= SELECT.
- The state machine has five states: IDLE, SELECT, EJECT, GAP and DONE.
- SELECT (exactly 1 cycle) evaluates in priority order:
  - rem==0 -> DONE.
  - rem>=5 and inv_q>0 -> EJECT quarter, rem-=5, inv_q-=1.
  - else rem>=2 and inv_d>0 -> EJECT dime, rem-=2, inv_d-=1.
  - else rem>=1 and inv_n>0 -> EJECT nickel, rem-=1, inv_n-=1.
  - else -> DONE with shortfall <= rem.
  - The rem and inventory updates occur on the SELECT->EJECT edge.
- EJECT: exactly one eject line is high for exactly PULSE_CYCLES cycles. The timer counts 0..PULSE_CYCLES-1, then clears, and the state moves to GAP.
- GAP: all eject lines are low for exactly GAP_CYCLES cycles, then the state moves to SELECT.
- DONE (1 cycle):
  - done=1.
  - short=1 iff shortfall!=0.
  - Next state is IDLE.
- Greedy is the decided policy. A greedy failure reports short even if a non-greedy combination existed. Coins already ejected are not recovered.
- At most one eject line is high in any cycle. Eject outputs are registered.
- Arithmetic:
  - rem never underflows, because selection guards on the comparisons.
  - Inventory never decrements below 0, because selection guards on >0.
- Latency:
  - amount=0: done is high in the 2nd cycle after the accept edge.
  - Each coin adds 1 + PULSE_CYCLES + GAP_CYCLES cycles.
- req_valid and req_amount are sampled only on the accept edge. Changes at other times are ignored.

Test Plan:
All scenarios use PULSE_CYCLES=4, GAP_CYCLES=2.
- Reset then load q=2,d=2,n=2; request 0 -> no eject; done pulse 2 cycles after accept; short=0; inventory unchanged.
- Request 8 (40c) with q=2,d=2,n=2 -> eject_q 4 cycles, gap, eject_d 4 cycles, gap, eject_n 4 cycles; done; inventory 1/1/1; shortfall=0.
- Request 6 with q=1,d=3,n=0 -> one quarter ejected, then done with short=1, shortfall=1; inv_q=0, inv_d=3.
- Request 31 with inventory all 0 -> no eject; done and short together; shortfall=31.
- Assert load_en and req_valid in the same IDLE cycle -> load applied; request not accepted (req_ready=0); request accepted the following cycle once load_en drops.
- Deassert rst_n during an eject pulse -> eject line low in the same cycle (asynchronous); busy=0; inventory 0; after release, req_ready=1.
